fifo_stream_reader: RTL
=======================

# fifo_stream_reader

Read-side controller for the team's `synchronous_fifo`. It drains the FIFO through its `r_en`/`data_out`/`empty` port and presents the words downstream as a valid/ready stream. A 2-entry output buffer absorbs the FIFO's 1-cycle read latency, so sustained throughput is one word per cycle. It is the consumer counterpart to the writer that fills the FIFO, and it is the block the FIFO bench will later instantiate in place of the directed read stimulus.

## Interface
- `DATA_WIDTH`, 8, word width; must match the FIFO.
- `CNT_WIDTH`, 16, width of the delivered-word counter.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `en` input 1: when high, the block may issue FIFO reads; when low, no new reads are issued.
- `rd_en` output 1: FIFO read strobe, combinational.
- `fifo_data_out` input DATA_WIDTH: FIFO read data, valid the cycle after a read is issued.
- `fifo_empty` input 1: FIFO empty flag.
- `m_valid` output 1: downstream word available.
- `m_data` output DATA_WIDTH: downstream word, the buffer head.
- `m_ready` input 1: downstream accepts; a transfer occurs when `m_valid && m_ready`.
- `rd_count` output CNT_WIDTH: number of words delivered downstream.
- `busy` output 1: high when a read is in flight or the buffer is non-empty.

## Operation
- **State**
  - `occ`: buffer occupancy, 0..2.
  - `inflight`: 1 if `rd_en` was high in the previous cycle, else 0.
  - Buffer: 2-entry FIFO with head and tail pointers that wrap.
- **Read issue:** `rd_en = en && !fifo_empty && (occ + inflight - pop) < 2`, where `pop = m_valid && m_ready`.
  - `rd_en` never asserts while `fifo_empty` is high, so the block never underflows the FIFO.
- **Capture:** when `inflight` is 1, `fifo_data_out` is written at the buffer tail on that clock edge.
- **Output:** `m_valid = (occ != 0)`, `m_data` = buffer head.
  - `m_data` must hold stable while `m_valid && !m_ready`.
- **Occupancy update** on each edge: `occ_next = occ + inflight - pop`.
  - Simultaneous capture and pop leaves `occ` unchanged and advances both pointers.
- **Counter:** `rd_count` increments by 1 on every pop and wraps from 2^CNT_WIDTH-1 to 0. No saturation.
- **`en` deasserted mid-stream:** no new `rd_en`. An in-flight word is still captured, and buffered words still drain downstream.
- **`fifo_empty` rising while a read is in flight:** the in-flight word is still captured. The flag only gates new reads.
- **Overflow:** impossible by construction, since the issue rule reserves a slot for every in-flight read. The bench asserts `occ <= 2` every cycle.
- **Reset (`rst_n` low, any time):** immediately clears `occ`, `inflight`, both pointers and `rd_count`.
  - A read strobed in the cycle reset asserts is discarded; the FIFO is reset alongside.

## Timing
- Reset values: `rd_en` = 0 (because `inflight`/`occ` are clear, and `rd_en` is forced low while `rst_n` is low), `m_valid` = 0, `m_data` = 0, `rd_count` = 0, `busy` = 0.
- **Latency:** `rd_en` high in cycle N → data captured at the end of cycle N+1 → `m_valid` high in cycle N+2.
  - First word after `fifo_empty` falls in cycle N: `m_valid` rises in cycle N+2.
- **Throughput:** with `m_ready` held high and the FIFO non-empty, `rd_en` stays high every cycle and one word transfers per cycle.
  - Steady state is `occ` = 1, `inflight` = 1.
- **Backpressure:** with `m_ready` low, at most 2 words are buffered, and `rd_en` drops once `occ + inflight` = 2.
  - `m_ready` rising again allows `rd_en` in that same cycle.
- **Order:** words are delivered downstream in exact FIFO order, with no loss and no duplication.
- **`busy`:** `busy = inflight || (occ != 0)`.

## Test plan
- **Single word:** after reset, write 0xA5 into the FIFO, `en` = 1, `m_ready` = 1 → exactly one `rd_en` pulse; `m_valid` high for one cycle, 2 cycles after `rd_en`, with `m_data` = 0xA5; `rd_count` = 1; `busy` low afterwards.
- **Full drain:** fill the FIFO with 8 words 0x00..0x07, then `en` = 1, `m_ready` = 1 → 8 consecutive `rd_en` cycles; `m_data` 0x00..0x07 on 8 consecutive cycles; `rd_count` = 8; `rd_en` never high while `fifo_empty` = 1.
- **Backpressure:** FIFO holding 8 words, `m_ready` = 0 for 10 cycles → exactly 2 `rd_en` pulses, `occ` = 2, `m_data` stable at the first word. Then `m_ready` = 1 → the remaining 6 words follow in order, gap-free after resumption.
- **Pause:** drop `en` after the 3rd `rd_en` → no further `rd_en`; the 3 words are still delivered. Raise `en` → the remaining words continue in order.
- **Reset mid-stream:** assert `rst_n` low while `occ` = 2 and a read is in flight → `m_valid` = 0, `rd_count` = 0 and `rd_en` = 0 immediately; no stale word appears after reset releases.
- **Counter wrap:** with `CNT_WIDTH` = 4, stream 17 words → `rd_count` reads 0 after the 16th word and 1 after the 17th.

Source files
------------

// File: rtl/fifo_stream_reader.sv
// Read-side controller for synchronous_fifo: drains the FIFO into a 2-entry skid
// buffer and presents the words downstream as a valid/ready stream.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  output logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic                  busy
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  logic [1:0]                 r_occ;
  logic                       r_inflight;
  logic                       r_head;
  logic                       r_tail;
  logic [1:0][DATA_WIDTH-1:0] r_buf;
  logic [CNT_WIDTH-1:0]       r_count;

  logic                       w_pop;
  logic [1:0]                 w_level;

  assign m_valid  = (r_occ != 2'd0);
  assign m_data   = r_buf[r_head];
  assign w_pop    = m_valid & m_ready;
  // Slots committed after this edge; a pop implies occ >= 1, so this never underflows.
  assign w_level  = r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
  // Issuing only when a slot stays free for the returning word makes overflow impossible.
  assign rd_en    = rst_n & en & ~fifo_empty & (w_level < 2'd2);
  assign busy     = r_inflight | m_valid;
  assign rd_count = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ      <= 2'd0;
      r_inflight <= 1'b0;
      r_head     <= 1'b0;
      r_tail     <= 1'b0;
      r_buf      <= '0;
      r_count    <= '0;
    end else begin
      r_inflight <= rd_en;
      r_occ      <= w_level;
      if (r_inflight) begin
        r_buf[r_tail] <= fifo_data_out;
        r_tail        <= ~r_tail;
      end
      if (w_pop) begin
        r_head  <= ~r_head;
        r_count <= r_count + CNT_ONE;
      end
    end
  end

endmodule
